// File: rtl/mem_access_pkg.sv
// Shared types for the memory/peripheral access unit: FSM state and decode region codes.
package mem_access_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RAM_RD = 2'd1,
    P_WAIT = 2'd2,
    DONE   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    REG_RAM = 2'd0,
    REG_PER = 2'd1,
    REG_UNM = 2'd2
  } region_e;

  // Index width that stays legal when there is only one item.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_addr_decode.sv
// Combinational address decode: RAM, one of NCH peripheral channels, or unmapped.
module mem_addr_decode
  import mem_access_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int RAM_AW      = 8,
  parameter int PERIPH_BASE = 'h100,
  parameter int NCH         = 4,
  parameter int CH_AW       = 4,
  parameter int CHW         = idx_w(NCH)
) (
  input  logic [ADDR_W-1:0] addr_i,
  output region_e           region_o,
  output logic [CHW-1:0]    ch_o,
  output logic [NCH-1:0]    sel_o,
  output logic [CH_AW-1:0]  off_o
);

  localparam logic [ADDR_W-1:0] RAM_TOP = ADDR_W'(1) << RAM_AW;
  localparam logic [ADDR_W-1:0] PER_LO  = ADDR_W'(PERIPH_BASE);
  localparam logic [ADDR_W-1:0] PER_HI  = ADDR_W'(PERIPH_BASE + NCH * (2 ** CH_AW));

  logic [ADDR_W-1:0] rel;

  always_comb begin
    rel      = addr_i - PER_LO;
    region_o = REG_UNM;
    ch_o     = '0;
    sel_o    = '0;
    off_o    = '0;
    if (addr_i < RAM_TOP) begin
      region_o = REG_RAM;
    end else if (addr_i >= PER_LO && addr_i < PER_HI) begin
      region_o = REG_PER;
      ch_o     = CHW'(rel >> CH_AW);
      sel_o    = NCH'(1) << ch_o;
      off_o    = CH_AW'(rel);
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store access unit between datapath, RAM and NCH ready-handshaked peripheral channels.
// Handshake: the datapath holds req_* stable while stall=1; rsp_valid=1 marks the completing cycle;
// p_sel stays asserted until the selected channel's p_ready or a timeout, and drops in DONE.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int DATA_W      = 64,
  parameter int ADDR_W      = 32,
  parameter int RAM_AW      = 8,
  parameter int PERIPH_BASE = 'h100,
  parameter int NCH         = 4,
  parameter int CH_AW       = 4,
  parameter int TIMEOUT     = 15
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_valid,
  output logic                  stall,
  output logic                  bus_err,
  input  logic                  err_clr,
  output logic [RAM_AW-1:0]     ram_addr,
  output logic [DATA_W-1:0]     ram_wdata,
  output logic                  ram_we,
  input  logic [DATA_W-1:0]     ram_rdata,
  output logic [NCH-1:0]        p_sel,
  output logic                  p_write,
  output logic [CH_AW-1:0]      p_addr,
  output logic [DATA_W-1:0]     p_wdata,
  input  logic [NCH*DATA_W-1:0] p_rdata,
  input  logic [NCH-1:0]        p_ready,
  output logic [1:0]            dbg_state
);

  localparam int CHW = idx_w(NCH);
  localparam int CW  = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  region_e          dec_region;
  logic [CHW-1:0]   dec_ch;
  logic [NCH-1:0]   dec_sel;
  logic [CH_AW-1:0] dec_off;

  mem_addr_decode #(
    .ADDR_W     (ADDR_W),
    .RAM_AW     (RAM_AW),
    .PERIPH_BASE(PERIPH_BASE),
    .NCH        (NCH),
    .CH_AW      (CH_AW),
    .CHW        (CHW)
  ) u_decode (
    .addr_i  (req_addr),
    .region_o(dec_region),
    .ch_o    (dec_ch),
    .sel_o   (dec_sel),
    .off_o   (dec_off)
  );

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [NCH-1:0]     sel_q, sel_d;
  logic [CHW-1:0]     ch_q, ch_d;
  logic               pwr_q, pwr_d;
  logic [CH_AW-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]  pwdata_q, pwdata_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               err_q, err_d;

  logic               stall_c, rsp_valid_c, ram_we_c, ram_drive_c, err_set;
  logic               ch_ready;
  logic [DATA_W-1:0]  ch_rdata;

  assign ch_ready = p_ready[ch_q];
  assign ch_rdata = p_rdata[int'(ch_q)*DATA_W +: DATA_W];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    ch_d        = ch_q;
    pwr_d       = pwr_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rdata_d     = rdata_q;
    stall_c     = 1'b0;
    rsp_valid_c = 1'b0;
    ram_we_c    = 1'b0;
    ram_drive_c = 1'b0;
    err_set     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          unique case (dec_region)
            REG_RAM: begin
              ram_drive_c = 1'b1;
              if (req_write) begin
                ram_we_c    = 1'b1;
                rsp_valid_c = 1'b1;
              end else begin
                stall_c = 1'b1;
                state_d = RAM_RD;
              end
            end
            REG_PER: begin
              stall_c  = 1'b1;
              sel_d    = dec_sel;
              ch_d     = dec_ch;
              pwr_d    = req_write;
              paddr_d  = dec_off;
              pwdata_d = req_wdata;
              cnt_d    = '0;
              state_d  = P_WAIT;
            end
            default: begin
              stall_c = 1'b1;
              err_set = 1'b1;
              if (!req_write) rdata_d = '1;
              state_d = DONE;
            end
          endcase
        end
      end
      // Stall is held through RAM_RD so the instruction stays put until its DONE cycle.
      RAM_RD: begin
        stall_c = 1'b1;
        rdata_d = ram_rdata;
        state_d = DONE;
      end
      P_WAIT: begin
        stall_c = 1'b1;
        if (ch_ready || cnt_q == CNT_MAX) begin
          if (ch_ready) begin
            if (!pwr_q) rdata_d = ch_rdata;
          end else begin
            err_set = 1'b1;
            if (!pwr_q) rdata_d = '1;
          end
          sel_d    = '0;
          pwr_d    = 1'b0;
          paddr_d  = '0;
          pwdata_d = '0;
          cnt_d    = '0;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        rsp_valid_c = 1'b1;
        state_d     = IDLE;
      end
    endcase
    err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sel_q    <= '0;
      ch_q     <= '0;
      pwr_q    <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      ch_q     <= ch_d;
      pwr_q    <= pwr_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Reset also masks the combinational strobes so every output reads 0 while it is asserted.
  assign stall     = stall_c & reset;
  assign rsp_valid = rsp_valid_c & reset;
  assign ram_we    = ram_we_c & reset;
  assign ram_addr  = (ram_drive_c & reset) ? RAM_AW'(req_addr) : '0;
  assign ram_wdata = ram_we ? req_wdata : '0;

  assign rsp_rdata = rdata_q;
  assign bus_err   = err_q;
  assign p_sel     = sel_q;
  assign p_write   = pwr_q;
  assign p_addr    = paddr_q;
  assign p_wdata   = pwdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: RAM store/load, peripheral handshake, timeout, unmapped, reset.
module tb_mem_access_unit;

  logic         clock;
  logic         reset;
  logic         req_valid;
  logic         req_write;
  logic [31:0]  req_addr;
  logic [63:0]  req_wdata;
  logic [63:0]  rsp_rdata;
  logic         rsp_valid;
  logic         stall;
  logic         bus_err;
  logic         err_clr;
  logic [7:0]   ram_addr;
  logic [63:0]  ram_wdata;
  logic         ram_we;
  logic [63:0]  ram_rdata;
  logic [3:0]   p_sel;
  logic         p_write;
  logic [3:0]   p_addr;
  logic [63:0]  p_wdata;
  logic [255:0] p_rdata;
  logic [3:0]   p_ready;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int stall_cnt = 0;
  int psel_cnt  = 0;

  logic [63:0] mem [256];
  logic [63:0] ch_data [4];

  mem_access_unit dut (
    .clock    (clock),
    .reset    (reset),
    .req_valid(req_valid),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_rdata(rsp_rdata),
    .rsp_valid(rsp_valid),
    .stall    (stall),
    .bus_err  (bus_err),
    .err_clr  (err_clr),
    .ram_addr (ram_addr),
    .ram_wdata(ram_wdata),
    .ram_we   (ram_we),
    .ram_rdata(ram_rdata),
    .p_sel    (p_sel),
    .p_write  (p_write),
    .p_addr   (p_addr),
    .p_wdata  (p_wdata),
    .p_rdata  (p_rdata),
    .p_ready  (p_ready),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // synchronous-read RAM model
  always @(posedge clock) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Samples the current cycle (well after the last edge), then advances to 2 units past the next edge.
  task automatic tick();
    if (stall) stall_cnt++;
    if (p_sel != 4'b0) psel_cnt++;
    @(posedge clock);
    #2;
  endtask

  task automatic drive(input logic v, input logic w, input logic [31:0] a, input logic [63:0] d);
    req_valid = v;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!rsp_valid && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_done"}, {63'd0, rsp_valid}, 64'd1);
  endtask

  initial begin
    ch_data[0] = 64'hC0DE_0000_0000_0000;
    ch_data[1] = 64'hC0DE_1111_1111_1111;
    ch_data[2] = 64'hC0DE_2222_2222_2222;
    ch_data[3] = 64'hC0DE_3333_3333_3333;
    p_rdata = {ch_data[3], ch_data[2], ch_data[1], ch_data[0]};
    p_ready = 4'b0;
    err_clr = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 64'h0);
    reset = 1'b0;
    #3;
    chk("rst_stall", {63'd0, stall}, 64'd0);
    chk("rst_psel", {60'd0, p_sel}, 64'd0);
    chk("rst_bus_err", {63'd0, bus_err}, 64'd0);
    chk("rst_rdata", rsp_rdata, 64'd0);
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_state", {62'd0, dbg_state}, 64'd0);
    #15 reset = 1'b1;
    tick();

    // 1: RAM store then load
    drive(1'b1, 1'b1, 32'h05, 64'hDEAD);
    #1;
    chk("st_ram_we", {63'd0, ram_we}, 64'd1);
    chk("st_stall", {63'd0, stall}, 64'd0);
    chk("st_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    chk("st_ram_addr", {56'd0, ram_addr}, 64'h05);
    chk("st_ram_wdata", ram_wdata, 64'hDEAD);
    tick();
    stall_cnt = 0;
    drive(1'b1, 1'b0, 32'h05, 64'h0);
    #1;
    chk("ld_ram_we", {63'd0, ram_we}, 64'd0);
    chk("ld_stall", {63'd0, stall}, 64'd1);
    chk("ld_ram_addr", {56'd0, ram_addr}, 64'h05);
    tick();
    chk("ld_state_rd", {62'd0, dbg_state}, 64'd1);
    tick();
    chk("ld_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    chk("ld_rdata", rsp_rdata, 64'hDEAD);
    chk("ld_stall_done", {63'd0, stall}, 64'd0);
    chk("ld_stall_cycles", 64'(stall_cnt), 64'd2);
    drive(1'b0, 1'b0, 32'h0, 64'h0);
    tick();

    // 2: peripheral load from channel 1, ready on third wait cycle, other channels ignored
    stall_cnt = 0;
    psel_cnt  = 0;
    drive(1'b1, 1'b0, 32'h112, 64'h0);
    #1;
    chk("p1_accept_stall", {63'd0, stall}, 64'd1);
    tick();
    p_ready = 4'b1101;
    #1;
    chk("p1_sel", {60'd0, p_sel}, 64'b0010);
    chk("p1_addr", {60'd0, p_addr}, 64'd2);
    chk("p1_write", {63'd0, p_write}, 64'd0);
    tick();
    chk("p1_ignore_other", {62'd0, dbg_state}, 64'd2);
    tick();
    p_ready = 4'b0010;
    #1;
    tick();
    p_ready = 4'b0;
    chk("p1_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    chk("p1_rdata", rsp_rdata, ch_data[1]);
    chk("p1_sel_done", {60'd0, p_sel}, 64'd0);
    chk("p1_stall_cycles", 64'(stall_cnt), 64'd4);
    chk("p1_bus_err", {63'd0, bus_err}, 64'd0);
    drive(1'b0, 1'b0, 32'h0, 64'h0);
    tick();

    // 3: store to channel 3 that times out
    stall_cnt = 0;
    psel_cnt  = 0;
    drive(1'b1, 1'b1, 32'h130, 64'h55AA);
    #1;
    tick();
    chk("to_sel", {60'd0, p_sel}, 64'b1000);
    chk("to_write", {63'd0, p_write}, 64'd1);
    chk("to_wdata", p_wdata, 64'h55AA);
    chk("to_paddr", {60'd0, p_addr}, 64'd0);
    wait_done("to");
    chk("to_bus_err", {63'd0, bus_err}, 64'd1);
    chk("to_psel_cycles", 64'(psel_cnt), 64'd16);
    chk("to_stall_cycles", 64'(stall_cnt), 64'd17);
    chk("to_store_rdata_kept", rsp_rdata, ch_data[1]);
    drive(1'b0, 1'b0, 32'h0, 64'h0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    #1;
    chk("to_err_clr", {63'd0, bus_err}, 64'd0);

    // 4: unmapped load; set beats a simultaneous clear
    stall_cnt = 0;
    psel_cnt  = 0;
    drive(1'b1, 1'b0, 32'h200, 64'h0);
    err_clr = 1'b1;
    #1;
    chk("un_stall", {63'd0, stall}, 64'd1);
    chk("un_ram_we", {63'd0, ram_we}, 64'd0);
    tick();
    err_clr = 1'b0;
    #1;
    chk("un_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    chk("un_bus_err", {63'd0, bus_err}, 64'd1);
    chk("un_rdata", rsp_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("un_stall_cycles", 64'(stall_cnt), 64'd1);
    chk("un_psel_cycles", 64'(psel_cnt), 64'd0);
    drive(1'b0, 1'b0, 32'h0, 64'h0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    #1;
    chk("un_err_clr", {63'd0, bus_err}, 64'd0);

    // 5: ready on the exact timeout cycle completes normally
    psel_cnt = 0;
    drive(1'b1, 1'b0, 32'h120, 64'h0);
    #1;
    tick();
    repeat (15) tick();
    p_ready = 4'b0100;
    #1;
    chk("edge_state", {62'd0, dbg_state}, 64'd2);
    tick();
    p_ready = 4'b0;
    chk("edge_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    chk("edge_bus_err", {63'd0, bus_err}, 64'd0);
    chk("edge_rdata", rsp_rdata, ch_data[2]);
    chk("edge_psel_cycles", 64'(psel_cnt), 64'd16);
    drive(1'b0, 1'b0, 32'h0, 64'h0);
    tick();

    // 3b: load variant of the timeout returns all-ones
    drive(1'b1, 1'b0, 32'h130, 64'h0);
    #1;
    tick();
    wait_done("tol");
    chk("tol_rdata", rsp_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("tol_bus_err", {63'd0, bus_err}, 64'd1);
    drive(1'b0, 1'b0, 32'h0, 64'h0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;

    // 6: reset during P_WAIT, then a fresh request from IDLE
    drive(1'b1, 1'b0, 32'h100, 64'h0);
    #1;
    tick();
    tick();
    chk("rw_sel", {60'd0, p_sel}, 64'b0001);
    reset = 1'b0;
    #1;
    chk("rw_psel_reset", {60'd0, p_sel}, 64'd0);
    chk("rw_stall_reset", {63'd0, stall}, 64'd0);
    chk("rw_state_reset", {62'd0, dbg_state}, 64'd0);
    drive(1'b1, 1'b1, 32'h07, 64'h77);
    #1;
    chk("rw_we_masked", {63'd0, ram_we}, 64'd0);
    reset = 1'b1;
    #1;
    chk("rw_we_after", {63'd0, ram_we}, 64'd1);
    chk("rw_stall_after", {63'd0, stall}, 64'd0);
    tick();
    drive(1'b1, 1'b0, 32'h07, 64'h0);
    #1;
    chk("rw_ld_stall", {63'd0, stall}, 64'd1);
    tick();
    tick();
    chk("rw_ld_valid", {63'd0, rsp_valid}, 64'd1);
    chk("rw_ld_rdata", rsp_rdata, 64'h77);
    drive(1'b0, 1'b0, 32'h0, 64'h0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
